// File: rtl/imem_loader.sv
// imem_loader
// Boot-time writer for the instruction memory. Bytes arriving from the UART
// receiver are assembled into little-endian 32-bit words and written to
// consecutive word-aligned addresses. The core is held in reset until the
// whole image has been written.
//
// Stream format: 4-byte word count N (little-endian), then N words of
// 4 bytes each (little-endian, first byte of a group lands in bits [7:0]).
//
// Ports
//   clk         system clock, all state changes on posedge
//   rst_n       asynchronous active-low reset
//   byte_data   received byte
//   byte_valid  byte_data is valid this cycle
//   byte_ready  loader accepts a byte this cycle (transfer on valid && ready)
//   load_req    single-cycle request to restart loading from the header
//   wr_en       instruction memory write strobe, one cycle per word
//   wr_addr     byte address of the write (word_index * 4, zero-extended)
//   wr_data     word to write
//   cpu_rst_n   core reset, active-low; high only once the image is complete
//   load_error  header rejected (N too large); sticky until load_req/rst_n

module imem_loader #(
  parameter int NUM_OF_INST = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        load_req,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_rst_n,
  output logic        load_error
);

  // One extra bit so a count of exactly NUM_OF_INST words is representable.
  localparam int IDX_W = $clog2(NUM_OF_INST) + 1;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t             state_q,      state_d;
  logic [1:0]         byte_cnt_q,   byte_cnt_d;
  logic [23:0]        partial_q,    partial_d;
  logic [IDX_W-1:0]   word_index_q, word_index_d;
  logic [IDX_W-1:0]   count_q,      count_d;
  logic               byte_ready_q, byte_ready_d;
  logic               wr_en_q,      wr_en_d;
  logic [31:0]        wr_addr_q,    wr_addr_d;
  logic [31:0]        wr_data_q,    wr_data_d;
  logic               cpu_rst_n_q,  cpu_rst_n_d;
  logic               load_error_q, load_error_d;

  logic               accept;
  logic [31:0]        full_word;

  // A restart request masks the handshake in its own cycle so that no byte
  // can slip into the stream that is about to be discarded.
  assign accept    = byte_valid && byte_ready_q && !load_req;
  assign full_word = {byte_data, partial_q};

  // Next-state logic: byte assembly, header decode and write generation.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    partial_d    = partial_q;
    word_index_d = word_index_q;
    count_d      = count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (load_req) begin
      state_d      = ST_HDR;
      byte_cnt_d   = 2'd0;
      partial_d    = 24'd0;
      word_index_d = '0;
      count_d      = '0;
    end else if (accept) begin
      if (byte_cnt_q != 2'd3) begin
        // Bytes 0..2 of a group are parked until the 4th completes the word.
        case (byte_cnt_q)
          2'd0:    partial_d[7:0]   = byte_data;
          2'd1:    partial_d[15:8]  = byte_data;
          default: partial_d[23:16] = byte_data;
        endcase
        byte_cnt_d = byte_cnt_q + 2'd1;
      end else begin
        byte_cnt_d = 2'd0;
        partial_d  = 24'd0;
        case (state_q)
          ST_HDR: begin
            // Full 32-bit compare: a huge N must not alias to a small count.
            if (full_word == 32'd0) begin
              state_d = ST_DONE;
            end else if (full_word > 32'(NUM_OF_INST)) begin
              state_d = ST_ERR;
            end else begin
              state_d      = ST_DATA;
              word_index_d = '0;
              count_d      = full_word[IDX_W-1:0];
            end
          end
          ST_DATA: begin
            wr_en_d      = 1'b1;
            wr_addr_d    = 32'(word_index_q) << 2;
            wr_data_d    = full_word;
            word_index_d = word_index_q + IDX_W'(1);
            if (word_index_d == count_q) begin
              state_d = ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end

    // Status outputs are registered versions of what the next state implies,
    // so they change on the same edge that changes the state.
    byte_ready_d = ((state_d == ST_HDR) || (state_d == ST_DATA)) && !load_req;
    cpu_rst_n_d  = (state_d == ST_DONE);
    load_error_d = (state_d == ST_ERR);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HDR;
      byte_cnt_q   <= 2'd0;
      partial_q    <= 24'd0;
      word_index_q <= '0;
      count_q      <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 32'd0;
      wr_data_q    <= 32'd0;
      cpu_rst_n_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      partial_q    <= partial_d;
      word_index_q <= word_index_d;
      count_q      <= count_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      load_error_q <= load_error_d;
    end
  end

  // load_req gates ready in its own cycle as well as the cycle after.
  assign byte_ready = byte_ready_q && !load_req;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader. A byte-stream model derives the
// expected outputs from the bytes accepted since the last restart; a compare
// process checks the DUT against it every cycle, and directed tests pin the
// captured writes to hand-computed addresses and data.

module tb_imem_loader;

  localparam int NUM_INST = 1024;

  logic        clk;
  logic        rst_n;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        load_req;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst_n;
  logic        load_error;

  int errors = 0;
  int checks = 0;

  imem_loader #(.NUM_OF_INST(NUM_INST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .load_req   (load_req),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_rst_n  (cpu_rst_n),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: everything follows from the list of bytes accepted since restart.
  // ---------------------------------------------------------------------------
  logic [7:0]  modelBytes[$];
  logic        expReady, expWrEn, expCpu, expErr;
  logic [31:0] expAddr, expData;

  function automatic logic [31:0] headerN();
    return {modelBytes[3], modelBytes[2], modelBytes[1], modelBytes[0]};
  endfunction

  // 0 = still loading, 1 = image complete, 2 = header rejected
  function automatic int imageStatus();
    logic [31:0] n;
    if (modelBytes.size() < 4) return 0;
    n = headerN();
    if (n == 32'd0) return 1;
    if (n > 32'(NUM_INST)) return 2;
    if (modelBytes.size() == 4 + 4 * int'(n)) return 1;
    return 0;
  endfunction

  initial begin
    int sz;
    int st;
    logic [31:0] n;
    expReady = 1'b0; expWrEn = 1'b0; expCpu = 1'b0; expErr = 1'b0;
    expAddr = 32'd0; expData = 32'd0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        modelBytes.delete();
        expReady = 1'b0; expWrEn = 1'b0; expCpu = 1'b0; expErr = 1'b0;
        expAddr = 32'd0; expData = 32'd0;
      end else begin
        expWrEn = 1'b0;
        if (load_req) begin
          modelBytes.delete();
          expReady = 1'b0;
        end else begin
          if (byte_valid && expReady) begin
            modelBytes.push_back(byte_data);
            sz = modelBytes.size();
            if (sz > 4 && (sz % 4) == 0) begin
              n = headerN();
              if (n != 32'd0 && n <= 32'(NUM_INST)) begin
                // Data word k (1-based) ends at byte 4+4k, address (k-1)*4.
                expWrEn = 1'b1;
                expAddr = 32'(sz - 8);
                expData = {modelBytes[sz-1], modelBytes[sz-2],
                           modelBytes[sz-3], modelBytes[sz-4]};
              end
            end
          end
          expReady = (imageStatus() == 0);
        end
        st = imageStatus();
        expCpu = (st == 1);
        expErr = (st == 2);
      end
    end
  end

  // Captured writes for the directed checks.
  logic [31:0] capAddr[$];
  logic [31:0] capData[$];

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checkFlag("cyc_byte_ready", byte_ready, expReady && !load_req);
      checkFlag("cyc_wr_en", wr_en, expWrEn);
      checkFlag("cyc_cpu_rst_n", cpu_rst_n, expCpu);
      checkFlag("cyc_load_error", load_error, expErr);
      if (expWrEn) begin
        checkOutput("cyc_wr_addr", wr_addr, expAddr);
        checkOutput("cyc_wr_data", wr_data, expData);
      end
      if (wr_en) begin
        capAddr.push_back(wr_addr);
        capData.push_back(wr_data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic applyStimulus(input logic [7:0] b, input int gapPct);
    logic accepted;
    for (int g = 0; g < 8; g++) begin
      if (int'($urandom_range(99)) >= gapPct) break;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    accepted   = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      accepted = byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    checkFlag("byte_accepted", accepted, 1'b1);
  endtask

  task automatic sendWord(input logic [31:0] w, input int gapPct);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(w[8*k +: 8], gapPct);
    end
  endtask

  task automatic pulseLoadReq(input logic offerByte);
    load_req   = 1'b1;
    byte_valid = offerByte;
    byte_data  = 8'h77;
    @(posedge clk); #1;
    load_req   = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clearCapture();
    capAddr.delete();
    capData.delete();
  endtask

  task automatic checkWrite(input int idx, input logic [31:0] addr, input logic [31:0] data);
    if (idx < capAddr.size()) begin
      checkOutput("write_addr", capAddr[idx], addr);
      checkOutput("write_data", capData[idx], data);
    end else begin
      checkOutput("write_missing", 32'(capAddr.size()), 32'(idx + 1));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkFlag({tag, "_byte_ready"}, byte_ready, 1'b0);
    checkFlag({tag, "_wr_en"}, wr_en, 1'b0);
    checkOutput({tag, "_wr_addr"}, wr_addr, 32'd0);
    checkOutput({tag, "_wr_data"}, wr_data, 32'd0);
    checkFlag({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
    checkFlag({tag, "_load_error"}, load_error, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; load_req = 1'b0;
    waitCycles(3);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    waitCycles(1);
    checkFlag("ready_after_reset", byte_ready, 1'b1);

    // Four-word program.
    $display("[TB] test: 4-word image");
    clearCapture();
    sendWord(32'd4, 0);
    sendWord(32'h00500093, 0);
    sendWord(32'h00100113, 0);
    sendWord(32'h002081B3, 0);
    sendWord(32'h0000006F, 0);
    checkFlag("last_write_wr_en", wr_en, 1'b1);
    checkFlag("last_write_cpu_rst_n", cpu_rst_n, 1'b1);
    checkFlag("done_ready", byte_ready, 1'b0);
    waitCycles(2);
    checkOutput("img4_count", 32'(capAddr.size()), 32'd4);
    checkWrite(0, 32'd0,  32'h00500093);
    checkWrite(1, 32'd4,  32'h00100113);
    checkWrite(2, 32'd8,  32'h002081B3);
    checkWrite(3, 32'd12, 32'h0000006F);
    // Bytes offered in DONE must be backpressured.
    byte_valid = 1'b1; byte_data = 8'hEE;
    waitCycles(3);
    byte_valid = 1'b0;
    checkOutput("done_no_extra_write", 32'(capAddr.size()), 32'd4);
    pulseLoadReq(1'b0);

    // Zero-length image.
    $display("[TB] test: empty image");
    clearCapture();
    sendWord(32'd0, 0);
    checkFlag("empty_cpu_rst_n", cpu_rst_n, 1'b1);
    checkFlag("empty_wr_en", wr_en, 1'b0);
    waitCycles(2);
    checkOutput("empty_count", 32'(capAddr.size()), 32'd0);
    pulseLoadReq(1'b0);

    // Oversized header, then recovery.
    $display("[TB] test: oversized header");
    clearCapture();
    sendWord(32'd1025, 0);
    checkFlag("err_load_error", load_error, 1'b1);
    checkFlag("err_cpu_rst_n", cpu_rst_n, 1'b0);
    checkFlag("err_ready", byte_ready, 1'b0);
    waitCycles(3);
    checkFlag("err_sticky", load_error, 1'b1);
    checkOutput("err_count", 32'(capAddr.size()), 32'd0);
    pulseLoadReq(1'b0);
    checkFlag("err_cleared", load_error, 1'b0);
    checkFlag("ready_low_after_req", byte_ready, 1'b0);
    sendWord(32'd1, 0);
    sendWord(32'hDEADBEEF, 0);
    checkFlag("recover_cpu_rst_n", cpu_rst_n, 1'b1);
    waitCycles(2);
    checkOutput("recover_count", 32'(capAddr.size()), 32'd1);
    checkWrite(0, 32'd0, 32'hDEADBEEF);
    pulseLoadReq(1'b0);

    // Three words with idle gaps between bytes.
    $display("[TB] test: gapped 3-word image");
    clearCapture();
    sendWord(32'd3, 50);
    sendWord(32'h11223344, 50);
    sendWord(32'hA5A55A5A, 50);
    sendWord(32'hCAFEF00D, 50);
    waitCycles(2);
    checkOutput("gap_count", 32'(capAddr.size()), 32'd3);
    checkWrite(0, 32'd0, 32'h11223344);
    checkWrite(1, 32'd4, 32'hA5A55A5A);
    checkWrite(2, 32'd8, 32'hCAFEF00D);
    pulseLoadReq(1'b0);

    // Restart with a partial word pending; byte offered alongside load_req.
    $display("[TB] test: restart mid-word");
    clearCapture();
    sendWord(32'd2, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    pulseLoadReq(1'b1);
    sendWord(32'd2, 0);
    sendWord(32'h0BADC0DE, 0);
    sendWord(32'h12345678, 0);
    waitCycles(2);
    checkOutput("restart_count", 32'(capAddr.size()), 32'd2);
    checkWrite(0, 32'd0, 32'h0BADC0DE);
    checkWrite(1, 32'd4, 32'h12345678);
    pulseLoadReq(1'b0);

    // Asynchronous reset in the middle of a data word.
    $display("[TB] test: async reset mid-word");
    clearCapture();
    sendWord(32'd3, 0);
    sendWord(32'h01010101, 0);
    sendWord(32'h02020202, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h44, 0);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    waitCycles(2);
    rst_n = 1'b1;
    clearCapture();
    waitCycles(1);
    sendWord(32'd1, 0);
    sendWord(32'h5A5A0001, 0);
    waitCycles(2);
    checkOutput("post_reset_count", 32'(capAddr.size()), 32'd1);
    checkWrite(0, 32'd0, 32'h5A5A0001);
    checkFlag("post_reset_cpu_rst_n", cpu_rst_n, 1'b1);

    waitCycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It accepts a byte stream from the UART receiver and assembles bytes into little-endian 32-bit words. It writes each word into the instruction memory write port at consecutive word-aligned addresses, holding the core in reset until the image is loaded. It sits between the UART receiver and the instruction memory, and is the only agent that writes instruction memory contents.

## Interface

- NUM_OF_INST, 1024: instruction memory depth in 32-bit words; largest loadable image.
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- byte_data  in  8  received byte.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
- load_req  in  1  single-cycle request to restart loading from header.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  32  byte address of the write, word aligned: word_index*4.
- wr_data  out  32  word to write.
- cpu_rst_n  out  1  core reset, active-low; high only when the image is complete.
- load_error  out  1  header rejected; sticky until load_req or rst_n.

## Operation

- Stream format: 4-byte header N (word count, little-endian), then N words, each 4 bytes little-endian; first byte of a group lands in bits [7:0].
- States: HDR, DATA, DONE, ERR. Reset state HDR; byte counter 0, word_index 0.
- HDR: accept 4 bytes. On the 4th byte:
  - N==0 goes to DONE.
  - N>NUM_OF_INST goes to ERR.
  - Otherwise goes to DATA with word_index=0 and count=N.
- DATA: accept bytes. On each 4th byte, issue a write of the assembled word at wr_addr=word_index*4, then increment word_index. The byte that completes word count-1 goes to DONE.
- DONE: byte_ready=0, cpu_rst_n=1. Incoming bytes are not accepted (backpressured).
- ERR: byte_ready=0, load_error=1, cpu_rst_n=0.
- load_req in any state goes to HDR. It clears the byte counter, word_index, partial word and load_error, and drives cpu_rst_n=0. A byte offered in the same cycle as load_req is not accepted; byte_ready is 0 that cycle.
- N is a full 32-bit unsigned compare against NUM_OF_INST; there is no truncation. word_index width is ≥ clog2(NUM_OF_INST)+1. wr_addr is zero-extended to 32 bits.

## Timing

- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_rst_n=0, load_error=0.
- byte_ready is registered. It rises on the first clk edge after rst_n deasserts, and equals (next state is HDR or DATA) && !load_req.
  - byte_ready drops on the same edge that enters DONE or ERR.
  - It stays low for one cycle after a load_req.
- Write latency: wr_en, wr_addr and wr_data are registered. They are valid for exactly one cycle, the cycle after the edge that accepted the 4th byte of a word.
- wr_en is never asserted for header bytes, and never asserted in DONE or ERR. The last word's wr_en coincides with the first cycle of DONE.
- cpu_rst_n rises on the edge that enters DONE, so the core leaves reset in the same cycle as the final write. The write commits on that cycle's posedge, before any core fetch.
- Back-to-back bytes (byte_valid held high) are accepted one per cycle, with no bubbles inside HDR or DATA.
- If rst_n is asserted mid-load, all state clears immediately and any partial word is discarded. Memory contents already written are not cleared.

## Test plan

- Reset then stream 04 00 00 00 followed by 4 words 0x00500093, 0x00100113, 0x002081B3, 0x0000006F as LE bytes: wr_en pulses 4 times at addresses 0, 4, 8, 12 with those words; cpu_rst_n rises on the last write cycle; byte_ready=0 afterwards.
- Header 00 00 00 00 -> DONE with no wr_en pulse; cpu_rst_n=1 one cycle after the 4th header byte is accepted.
- Header with N=1025 (01 04 00 00), default parameter -> ERR: load_error=1, cpu_rst_n=0, byte_ready=0, no writes. Then pulse load_req: load_error=0, and a valid 1-word load at address 0 succeeds.
- Random byte_valid gaps (about 50% idle) on a 3-word image: writes, addresses and data are identical to the gap-free case; exactly 3 wr_en pulses.
- load_req after 2 bytes of word 1 of a 2-word image, then a fresh 2-word header and data: partial bytes discarded; writes go to addresses 0 and 4 with the new data only.
- Assert rst_n low mid-word in DATA: all outputs return to their reset values asynchronously; after release, a new header restarts loading at address 0.
